rv32_id_stage: RTL and testbench

Registered decode/operand-select stage directly upstream of the RV32I ALU. Accepts one fetched instruction plus PC and register-file read data per handshake. Decodes the instruction into the ALU operand pair and 4-bit ALU opcode, plus writeback and memory control. Holds the result in an output pipeline register with a valid/ready handshake toward execute.

---
 rtl/rv32_id_stage.sv | 201 ++++++++++++++++++++
 tb/tb_rv32_id_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_id_stage.sv
// RV32I decode / operand-select stage feeding the ALU through a valid/ready output register.
// Define RV32_ID_SKID_EN to add a second skid entry with a registered instr_ready_out.
module rv32_id_stage #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] LINK_OFFSET = 32'd4
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            flush_in,
    input  logic            instr_valid_in,
    output logic            instr_ready_out,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [4:0]      rs1_addr_out,
    output logic [4:0]      rs2_addr_out,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    output logic            ex_valid_out,
    input  logic            ex_ready_in,
    output logic [XLEN-1:0] op_1_out,
    output logic [XLEN-1:0] op_2_out,
    output logic [3:0]      opcode_out,
    output logic [4:0]      rd_addr_out,
    output logic            rd_wr_en_out,
    output logic            mem_rd_out,
    output logic            mem_wr_out,
    output logic [XLEN-1:0] store_data_out,
    output logic            illegal_out
);

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [3:0]      alu_op;
        logic [4:0]      rd;
        logic            wr_en;
        logic            mem_rd;
        logic            mem_wr;
        logic [XLEN-1:0] st_data;
        logic            illegal;
    } bundle_t;

    bundle_t bundle_d;
    bundle_t main_q;
    logic    main_valid_q;

    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_sh;
    logic            is_shift;
    logic            bad;
    logic            wr;

    assign rs1_addr_out = instr_in[19:15];
    assign rs2_addr_out = instr_in[24:20];

    assign funct3   = instr_in[14:12];
    assign funct7   = instr_in[31:25];
    assign imm_i    = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s    = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b    = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u    = {instr_in[31:12], 12'b0};
    assign imm_sh   = {27'b0, instr_in[24:20]};
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        bundle_d = '0;
        bad      = 1'b0;
        wr       = 1'b0;
        if (instr_in[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            unique case (instr_in[6:2])
                5'b01100: begin
                    bundle_d.op1    = rs1_data_in;
                    bundle_d.op2    = rs2_data_in;
                    bundle_d.alu_op = {instr_in[30], funct3};
                    wr              = 1'b1;
                    if (funct7 != 7'h00 && funct7 != 7'h20)
                        bad = 1'b1;
                    if (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101)
                        bad = 1'b1;
                end
                5'b00100: begin
                    bundle_d.op1    = rs1_data_in;
                    bundle_d.op2    = is_shift ? imm_sh : imm_i;
                    bundle_d.alu_op = {(funct3 == 3'b101) & instr_in[30], funct3};
                    wr              = 1'b1;
                    // SLLI only allows funct7 0; SRLI/SRAI allow 0x00 / 0x20
                    if (is_shift && funct7 != 7'h00 &&
                        !(funct3 == 3'b101 && funct7 == 7'h20))
                        bad = 1'b1;
                end
                5'b01101: begin
                    bundle_d.op2 = imm_u;
                    wr           = 1'b1;
                end
                5'b00101: begin
                    bundle_d.op1 = pc_in;
                    bundle_d.op2 = imm_u;
                    wr           = 1'b1;
                end
                5'b00000: begin
                    bundle_d.op1    = rs1_data_in;
                    bundle_d.op2    = imm_i;
                    bundle_d.mem_rd = 1'b1;
                    wr              = 1'b1;
                end
                5'b01000: begin
                    bundle_d.op1     = rs1_data_in;
                    bundle_d.op2     = imm_s;
                    bundle_d.mem_wr  = 1'b1;
                    bundle_d.st_data = rs2_data_in;
                end
                5'b11011, 5'b11001: begin
                    bundle_d.op1 = pc_in;
                    bundle_d.op2 = LINK_OFFSET;
                    wr           = 1'b1;
                end
                5'b11000: begin
                    bundle_d.op1 = pc_in;
                    bundle_d.op2 = imm_b;
                end
                5'b00011, 5'b11100: begin
                end
                default: bad = 1'b1;
            endcase
        end
        if (bad)
            bundle_d = '0;
        bundle_d.illegal = bad;
        bundle_d.rd      = instr_in[11:7];
        bundle_d.wr_en   = wr && !bad && (instr_in[11:7] != 5'd0);
    end

    logic accept, drain;
    assign drain  = main_valid_q & ex_ready_in;
    assign accept = instr_valid_in & instr_ready_out;

`ifdef RV32_ID_SKID_EN
    bundle_t skid_q;
    logic    skid_valid_q;

    assign instr_ready_out = !skid_valid_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else if (flush_in) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            if (drain) begin
                main_q       <= skid_q;
                skid_valid_q <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || drain) begin
                main_q       <= bundle_d;
                main_valid_q <= 1'b1;
            end else begin
                skid_q       <= bundle_d;
                skid_valid_q <= 1'b1;
            end
        end else if (drain) begin
            main_valid_q <= 1'b0;
        end
    end
`else
    assign instr_ready_out = !main_valid_q | ex_ready_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
        end else if (flush_in) begin
            main_valid_q <= 1'b0;
        end else if (accept) begin
            main_q       <= bundle_d;
            main_valid_q <= 1'b1;
        end else if (drain) begin
            main_valid_q <= 1'b0;
        end
    end
`endif

    assign ex_valid_out   = main_valid_q;
    assign op_1_out       = main_q.op1;
    assign op_2_out       = main_q.op2;
    assign opcode_out     = main_q.alu_op;
    assign rd_addr_out    = main_q.rd;
    assign rd_wr_en_out   = main_q.wr_en;
    assign mem_rd_out     = main_q.mem_rd;
    assign mem_wr_out     = main_q.mem_wr;
    assign store_data_out = main_q.st_data;
    assign illegal_out    = main_q.illegal;

endmodule

// File: tb/tb_rv32_id_stage.sv
// Randomized + directed bench for rv32_id_stage against a queue-based reference model.
module tb_rv32_id_stage;

`ifdef RV32_ID_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        flush_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic [31:0] instr_in, pc_in, rs1_data_in, rs2_data_in;
    logic [4:0]  rs1_addr_out, rs2_addr_out;
    logic        ex_valid_out, ex_ready_in;
    logic [31:0] op_1_out, op_2_out, store_data_out;
    logic [3:0]  opcode_out;
    logic [4:0]  rd_addr_out;
    logic        rd_wr_en_out, mem_rd_out, mem_wr_out, illegal_out;

    rv32_id_stage dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
        .instr_in(instr_in), .pc_in(pc_in),
        .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in),
        .op_1_out(op_1_out), .op_2_out(op_2_out), .opcode_out(opcode_out),
        .rd_addr_out(rd_addr_out), .rd_wr_en_out(rd_wr_en_out),
        .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out),
        .store_data_out(store_data_out), .illegal_out(illegal_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] op1, op2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        wr, mrd, mwr;
        logic [31:0] sd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e = '0;
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        logic [31:0] i_imm = 32'($signed(w) >>> 20);
        logic [31:0] u_imm = w & 32'hFFFF_F000;
        logic [31:0] s_imm = (i_imm & ~32'h1F) | {27'b0, w[11:7]};
        logic [31:0] b_imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        bit shift = (f3 == 1) || (f3 == 5);
        bit ok = 1;
        case (w[6:0])
            7'h33: begin
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                e.op1 = a; e.op2 = b; e.alu = {w[30], w[14:12]}; e.wr = 1;
            end
            7'h13: begin
                ok = !shift || f7 == 0 || (f3 == 5 && f7 == 32);
                e.op1 = a; e.op2 = shift ? {27'b0, w[24:20]} : i_imm;
                e.alu = {(f3 == 5) && w[30], w[14:12]}; e.wr = 1;
            end
            7'h37: begin e.op2 = u_imm; e.wr = 1; end
            7'h17: begin e.op1 = pc; e.op2 = u_imm; e.wr = 1; end
            7'h03: begin e.op1 = a; e.op2 = i_imm; e.wr = 1; e.mrd = 1; end
            7'h23: begin e.op1 = a; e.op2 = s_imm; e.mwr = 1; e.sd = b; end
            7'h6F, 7'h67: begin e.op1 = pc; e.op2 = 32'd4; e.wr = 1; end
            7'h63: begin e.op1 = pc; e.op2 = b_imm; end
            7'h0F, 7'h73: ;
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '0;
            e.ill = 1;
        end
        e.rd = w[11:7];
        if (e.rd == 0) e.wr = 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23,
                                 7'h6F, 7'h67, 7'h63, 7'h0F, 7'h73};
        if ($urandom_range(9) == 0) return w;
        w[6:0] = ops[$urandom_range(10)];
        if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(3) != 0)
            w[31:25] = $urandom_range(1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    // One cycle: drive at the falling edge, compare against the model, advance the model.
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic rdy, input logic fl, output logic acc);
        logic exp_rdy;
        instr_valid_in = v; instr_in = w; pc_in = pc;
        rs1_data_in = a; rs2_data_in = b; ex_ready_in = rdy; flush_in = fl;
        #1;
        exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || rdy);
        check_val("ready", instr_ready_out, exp_rdy);
        check_val("rs1_addr", rs1_addr_out, w[19:15]);
        check_val("rs2_addr", rs2_addr_out, w[24:20]);
        check_val("ex_valid", ex_valid_out, q.size() != 0);
        if (q.size() != 0) begin
            check_val("op1", op_1_out, q[0].op1);
            check_val("op2", op_2_out, q[0].op2);
            check_val("alu_op", opcode_out, q[0].alu);
            check_val("rd", rd_addr_out, q[0].rd);
            check_val("wr_en", rd_wr_en_out, q[0].wr);
            check_val("mem_rd", mem_rd_out, q[0].mrd);
            check_val("mem_wr", mem_wr_out, q[0].mwr);
            check_val("st_data", store_data_out, q[0].sd);
            check_val("illegal", illegal_out, q[0].ill);
        end
        acc = v && exp_rdy && !fl;
        if (fl) q.delete();
        else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (acc) q.push_back(model(w, pc, a, b));
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        step(1'b0, 32'h0000_0013, 32'h0, 32'h0, 32'h0, rdy, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        int n, cyc;
        logic [31:0] stream [8];
        rst_n_in = 1'b0; flush_in = 0; instr_valid_in = 0; instr_in = 0;
        pc_in = 0; rs1_data_in = 0; rs2_data_in = 0; ex_ready_in = 0;
        repeat (3) @(negedge clk_in);
        check_val("rst_valid", ex_valid_out, 1'b0);
        rst_n_in = 1'b1;

        step(1, 32'h0020_81B3, 32'h100, 32'd5, 32'd7, 1, 0, acc);
        check_val("add_op1", op_1_out, 32'd5);
        check_val("add_op2", op_2_out, 32'd7);
        check_val("add_alu", opcode_out, 4'b0000);
        check_val("add_rd", rd_addr_out, 5'd3);
        check_val("add_wr", rd_wr_en_out, 1'b1);
        step(1, 32'h4020_81B3, 32'h104, 32'd5, 32'd7, 1, 0, acc);
        check_val("sub_alu", opcode_out, 4'b1000);
        step(1, 32'h4033_5293, 32'h108, 32'd9, 32'd0, 1, 0, acc);
        check_val("srai_op2", op_2_out, 32'd3);
        check_val("srai_alu", opcode_out, 4'b1101);
        step(1, 32'hFFF0_0093, 32'h10C, 32'd0, 32'd0, 1, 0, acc);
        check_val("addi_op1", op_1_out, 32'd0);
        check_val("addi_op2", op_2_out, 32'hFFFF_FFFF);
        check_val("addi_alu", opcode_out, 4'b0000);
        step(1, 32'h1234_52B7, 32'h110, 32'd1, 32'd2, 1, 0, acc);
        check_val("lui_op1", op_1_out, 32'd0);
        check_val("lui_op2", op_2_out, 32'h1234_5000);
        check_val("lui_rd", rd_addr_out, 5'd5);
        check_val("lui_wr", rd_wr_en_out, 1'b1);
        step(1, 32'h0000_0000, 32'h114, 32'd1, 32'd2, 1, 0, acc);
        check_val("zero_ill", illegal_out, 1'b1);
        check_val("zero_wr", rd_wr_en_out, 1'b0);
        idle(1);

        // stall with a held bundle, then flush with a same-cycle instruction
        step(1, 32'h0020_81B3, 32'h200, 32'd5, 32'd7, 1, 0, acc);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            check_val("hold_op1", op_1_out, 32'd5);
            check_val("hold_valid", ex_valid_out, 1'b1);
        end
        step(1, 32'h4020_81B3, 32'h204, 32'd1, 32'd1, 0, 1, acc);
        check_val("flush_valid", ex_valid_out, 1'b0);
        idle(1);
        check_val("flush_drop", ex_valid_out, 1'b0);

        // back-to-back stream of 8, one stall mid-stream
        for (int i = 0; i < 8; i++) stream[i] = 32'h0000_0093 | (i << 20) | ((i + 1) << 7);
        n = 0; cyc = 0;
        while (n < 8 && cyc < 40) begin
            step(1, stream[n], 32'h300 + n * 4, 32'd10, 32'd0, cyc != 3, 0, acc);
            if (acc) n++;
            cyc++;
        end
        check_val("stream_cnt", n, 8);
        repeat (3) idle(1);

        // reset mid-stream
        step(1, 32'h0010_0093, 32'h400, 32'hA5, 32'h5A, 0, 0, acc);
        check_val("pre_rst_valid", ex_valid_out, 1'b1);
        instr_valid_in = 0;
        #2 rst_n_in = 1'b0;
        #1;
        check_val("arst_valid", ex_valid_out, 1'b0);
        check_val("arst_op1", op_1_out, 32'd0);
        check_val("arst_op2", op_2_out, 32'd0);
        check_val("arst_alu", opcode_out, 4'd0);
        check_val("arst_rd", rd_addr_out, 5'd0);
        check_val("arst_wr", rd_wr_en_out, 1'b0);
        q.delete();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        idle(1);
        idle(1);

        for (int i = 0; i < 500; i++)
            step($urandom_range(3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                 $urandom_range(3) != 0, $urandom_range(19) == 0, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
